// File: rtl/pixel_stencil_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_stencil_pkg
//  Description : Shared types for the 3x3 pixel stencil engine: kernel
//                select, row state machine encoding and guard-bit count.
//  Revision    : 1.0 - initial release
// ============================================================================
package pixel_stencil_pkg;

    // Kernel applied to every pixel of a row.
    typedef enum logic [1:0] {
        PASS  = 2'd0,
        GAUSS = 2'd1,
        SOBEL = 2'd2,
        SHARP = 2'd3
    } stencil_mode_t;

    // Row sequencer states; HOLD and DRAIN both own one pending word.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } stencil_state_t;

    // Extra bits above PIX_W carried by every intermediate kernel sum.
    localparam int c_GUARD_BITS = 4;

endpackage : pixel_stencil_pkg
`default_nettype wire

// File: rtl/pixel_stencil_lane.sv
`default_nettype none
// ============================================================================
//  Module      : stencil_lane
//  Description : Purely combinational per-pixel kernel. Takes a 3x3
//                neighbourhood (top/mid/bot rows, left/centre/right columns)
//                and produces one unsigned result pixel for the chosen mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module stencil_lane
    import pixel_stencil_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] top_l,
    input  logic [PIX_W-1:0] top_c,
    input  logic [PIX_W-1:0] top_r,
    input  logic [PIX_W-1:0] mid_l,
    input  logic [PIX_W-1:0] mid_c,
    input  logic [PIX_W-1:0] mid_r,
    input  logic [PIX_W-1:0] bot_l,
    input  logic [PIX_W-1:0] bot_c,
    input  logic [PIX_W-1:0] bot_r,
    input  logic [1:0]       mode,
    output logic [PIX_W-1:0] pix
);

    localparam int SW = PIX_W + c_GUARD_BITS;

    localparam logic [SW-1:0]        c_ROUND   = SW'(8);
    localparam logic signed [SW-1:0] c_PIX_MAX = {{c_GUARD_BITS{1'b0}}, {PIX_W{1'b1}}};

    // Zero-extended copies of the neighbourhood at intermediate width.
    logic [SW-1:0] w_tl, w_tc, w_tr;
    logic [SW-1:0] w_ml, w_mc, w_mr;
    logic [SW-1:0] w_bl, w_bc, w_br;

    assign w_tl = {{c_GUARD_BITS{1'b0}}, top_l};
    assign w_tc = {{c_GUARD_BITS{1'b0}}, top_c};
    assign w_tr = {{c_GUARD_BITS{1'b0}}, top_r};
    assign w_ml = {{c_GUARD_BITS{1'b0}}, mid_l};
    assign w_mc = {{c_GUARD_BITS{1'b0}}, mid_c};
    assign w_mr = {{c_GUARD_BITS{1'b0}}, mid_r};
    assign w_bl = {{c_GUARD_BITS{1'b0}}, bot_l};
    assign w_bc = {{c_GUARD_BITS{1'b0}}, bot_c};
    assign w_br = {{c_GUARD_BITS{1'b0}}, bot_r};

    // Gaussian sum is never negative; its maximum (16*max + 8) still fits
    // the guard width when read as unsigned.
    logic [SW-1:0] w_gauss_sum;
    assign w_gauss_sum = w_tl + (w_tc << 1) + w_tr
                       + (w_ml << 1) + (w_mc << 2) + (w_mr << 1)
                       + w_bl + (w_bc << 1) + w_br + c_ROUND;

    // Sobel gradients: gx = right column minus left, gy = bottom minus top.
    logic signed [SW-1:0] w_gx, w_gy, w_abs_gx, w_abs_gy, w_sobel;
    assign w_gx     = $signed(w_tr + (w_mr << 1) + w_br) - $signed(w_tl + (w_ml << 1) + w_bl);
    assign w_gy     = $signed(w_bl + (w_bc << 1) + w_br) - $signed(w_tl + (w_tc << 1) + w_tr);
    assign w_abs_gx = w_gx[SW-1] ? -w_gx : w_gx;
    assign w_abs_gy = w_gy[SW-1] ? -w_gy : w_gy;
    assign w_sobel  = w_abs_gx + w_abs_gy;

    // Sharpen: 5c minus the four direct neighbours, may go negative.
    logic signed [SW-1:0] w_sharp;
    assign w_sharp = $signed((w_mc << 2) + w_mc) - $signed(w_tc) - $signed(w_bc)
                   - $signed(w_ml) - $signed(w_mr);

    // Select the kernel result and saturate into the pixel range.
    always_comb begin
        pix = mid_c;
        case (stencil_mode_t'(mode))
            PASS:  pix = mid_c;
            GAUSS: pix = PIX_W'(w_gauss_sum >> 4);
            SOBEL: begin
                if (w_sobel > c_PIX_MAX) begin
                    pix = {PIX_W{1'b1}};
                end else begin
                    pix = w_sobel[PIX_W-1:0];
                end
            end
            SHARP: begin
                if (w_sharp[SW-1]) begin
                    pix = '0;
                end else if (w_sharp > c_PIX_MAX) begin
                    pix = {PIX_W{1'b1}};
                end else begin
                    pix = w_sharp[PIX_W-1:0];
                end
            end
            default: pix = mid_c;
        endcase
    end

endmodule : stencil_lane
`default_nettype wire

// File: rtl/pixel_stencil.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_stencil
//  Description : Streaming 3x3 stencil over rows of LANES-pixel words.
//                One word is held back until its right neighbour (lane 0 of
//                the next word) arrives or the row ends, at which point the
//                right edge is replicated. Left edge uses the previous
//                word's last lane, or lane 0 replicated at a row start.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_stencil
    import pixel_stencil_pkg::*;
#(
    parameter int LANES = 4,
    parameter int PIX_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             cfg_mode,
    input  logic [LANES*PIX_W-1:0] in_top,
    input  logic [LANES*PIX_W-1:0] in_mid,
    input  logic [LANES*PIX_W-1:0] in_bot,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_first,
    input  logic                   in_last,
    output logic [LANES*PIX_W-1:0] out_pix,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy
);

    localparam int DW = LANES * PIX_W;

    stencil_state_t r_state, w_state_nxt;

    logic [DW-1:0]    r_pend_top, r_pend_mid, r_pend_bot;
    logic [PIX_W-1:0] r_left_top, r_left_mid, r_left_bot;
    logic [1:0]       r_row_mode;
    logic [DW-1:0]    r_out_pix;
    logic             r_out_valid;
    logic             r_out_last;

    logic             w_out_free;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_take;
    logic             w_new_row;
    logic             w_load;
    logic             w_load_last;
    logic             w_right_repl;
    logic [PIX_W-1:0] w_right_top, w_right_mid, w_right_bot;
    logic [DW-1:0]    w_calc;

    // The output register may be refilled when empty or being consumed now.
    assign w_out_free = !r_out_valid || out_ready;
    assign w_in_ready = !rst && (r_state != DRAIN) && w_out_free;
    assign w_accept   = in_valid && w_in_ready;

    assign in_ready  = w_in_ready;
    assign out_pix   = r_out_pix;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = (r_state != EMPTY) || r_out_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath control for the row sequencer.
    always_comb begin
        w_state_nxt  = r_state;
        w_take       = 1'b0;
        w_new_row    = 1'b0;
        w_load       = 1'b0;
        w_load_last  = 1'b0;
        w_right_repl = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_take      = 1'b1;
                    w_new_row   = 1'b1;
                    w_state_nxt = in_last ? DRAIN : HOLD;
                end
            end
            HOLD: begin
                // A new row start closes the current one at its right edge.
                w_right_repl = in_first;
                if (w_accept) begin
                    w_take      = 1'b1;
                    w_new_row   = in_first;
                    w_load      = 1'b1;
                    w_load_last = in_first;
                    w_state_nxt = in_last ? DRAIN : HOLD;
                end
            end
            DRAIN: begin
                w_right_repl = 1'b1;
                if (w_out_free) begin
                    w_load      = 1'b1;
                    w_load_last = 1'b1;
                    w_state_nxt = EMPTY;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    // Right neighbour of the pending word's last lane.
    assign w_right_top = w_right_repl ? r_pend_top[DW-1 -: PIX_W] : in_top[PIX_W-1:0];
    assign w_right_mid = w_right_repl ? r_pend_mid[DW-1 -: PIX_W] : in_mid[PIX_W-1:0];
    assign w_right_bot = w_right_repl ? r_pend_bot[DW-1 -: PIX_W] : in_bot[PIX_W-1:0];

    // One kernel per lane; edge lanes borrow from the neighbour sources.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [PIX_W-1:0] w_tl, w_ml, w_bl;
        logic [PIX_W-1:0] w_tr, w_mr, w_br;

        if (i == 0) begin : g_left_edge
            assign w_tl = r_left_top;
            assign w_ml = r_left_mid;
            assign w_bl = r_left_bot;
        end else begin : g_left_inner
            assign w_tl = r_pend_top[(i-1)*PIX_W +: PIX_W];
            assign w_ml = r_pend_mid[(i-1)*PIX_W +: PIX_W];
            assign w_bl = r_pend_bot[(i-1)*PIX_W +: PIX_W];
        end

        if (i == LANES-1) begin : g_right_edge
            assign w_tr = w_right_top;
            assign w_mr = w_right_mid;
            assign w_br = w_right_bot;
        end else begin : g_right_inner
            assign w_tr = r_pend_top[(i+1)*PIX_W +: PIX_W];
            assign w_mr = r_pend_mid[(i+1)*PIX_W +: PIX_W];
            assign w_br = r_pend_bot[(i+1)*PIX_W +: PIX_W];
        end

        stencil_lane #(
            .PIX_W (PIX_W)
        ) u_lane (
            .top_l (w_tl),
            .top_c (r_pend_top[i*PIX_W +: PIX_W]),
            .top_r (w_tr),
            .mid_l (w_ml),
            .mid_c (r_pend_mid[i*PIX_W +: PIX_W]),
            .mid_r (w_mr),
            .bot_l (w_bl),
            .bot_c (r_pend_bot[i*PIX_W +: PIX_W]),
            .bot_r (w_br),
            .mode  (r_row_mode),
            .pix   (w_calc[i*PIX_W +: PIX_W])
        );
    end

    // Pending word, left-neighbour history, row mode and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_top  <= '0;
            r_pend_mid  <= '0;
            r_pend_bot  <= '0;
            r_left_top  <= '0;
            r_left_mid  <= '0;
            r_left_bot  <= '0;
            r_row_mode  <= '0;
            r_out_pix   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_take) begin
                r_pend_top <= in_top;
                r_pend_mid <= in_mid;
                r_pend_bot <= in_bot;
                if (w_new_row) begin
                    // Row start: left neighbour is lane 0 replicated, and
                    // the kernel is frozen for the whole row.
                    r_left_top <= in_top[PIX_W-1:0];
                    r_left_mid <= in_mid[PIX_W-1:0];
                    r_left_bot <= in_bot[PIX_W-1:0];
                    r_row_mode <= cfg_mode;
                end else begin
                    r_left_top <= r_pend_top[DW-1 -: PIX_W];
                    r_left_mid <= r_pend_mid[DW-1 -: PIX_W];
                    r_left_bot <= r_pend_bot[DW-1 -: PIX_W];
                end
            end
            if (w_load) begin
                r_out_pix   <= w_calc;
                r_out_last  <= w_load_last;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule : pixel_stencil
`default_nettype wire

// File: tb/tb_pixel_stencil.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_stencil
//  Description : Self-checking bench for pixel_stencil. Directed cases plus
//                randomized rows checked against a whole-row image model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_stencil;

    localparam int L  = 4;
    localparam int W  = 8;
    localparam int DW = L * W;
    localparam int PMAX = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    cfg_mode;
    logic [DW-1:0] in_top, in_mid, in_bot;
    logic          in_valid, in_ready, in_first, in_last;
    logic [DW-1:0] out_pix;
    logic          out_valid, out_ready, out_last;
    logic          busy;

    pixel_stencil #(.LANES(L), .PIX_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_mode  (cfg_mode),
        .in_top    (in_top),
        .in_mid    (in_mid),
        .in_bot    (in_bot),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_pix   (out_pix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: the open row as plain pixel arrays.
    logic [DW:0] exp_q[$];
    logic [DW:0] obs_q[$];
    logic [DW:0] out_log[$];
    logic [DW:0] row_out[$];
    int          rt[$], rm[$], rb[$];
    bit          row_open = 0;
    int          row_mode = 0;
    int          row_words = 0;
    bit          last_acc;
    bit          rand_ready = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int clampi(int v);
        if (v < 0) return 0;
        if (v > PMAX) return PMAX;
        return v;
    endfunction

    function automatic int absi(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int ref_pix(int mode, int t0, int t1, int t2,
                                   int m0, int m1, int m2, int b0, int b1, int b2);
        int gx, gy;
        case (mode)
            1: return (t0 + 2*t1 + t2 + 2*m0 + 4*m1 + 2*m2 + b0 + 2*b1 + b2 + 8) / 16;
            2: begin
                gx = (t2 + 2*m2 + b2) - (t0 + 2*m0 + b0);
                gy = (b0 + 2*b1 + b2) - (t0 + 2*t1 + t2);
                return clampi(absi(gx) + absi(gy));
            end
            3: return clampi(5*m1 - t1 - b1 - m0 - m2);
            default: return m1;
        endcase
    endfunction

    // Compute every output word of the open row with edge replication.
    function automatic void build_row();
        int len, xl, xr, x, p;
        logic [DW-1:0] word;
        row_out.delete();
        len = rm.size();
        for (int w = 0; w < row_words; w++) begin
            word = '0;
            for (int l = 0; l < L; l++) begin
                x  = w*L + l;
                xl = (x == 0) ? 0 : x - 1;
                xr = (x == len - 1) ? len - 1 : x + 1;
                p  = ref_pix(row_mode, rt[xl], rt[x], rt[xr],
                             rm[xl], rm[x], rm[xr], rb[xl], rb[x], rb[xr]);
                word[l*W +: W] = p[W-1:0];
            end
            row_out.push_back({(w == row_words - 1), word});
        end
    endfunction

    function automatic void clear_row();
        rt.delete(); rm.delete(); rb.delete();
        row_words = 0;
        row_open  = 0;
    endfunction

    function automatic void close_row();
        build_row();
        foreach (row_out[i]) exp_q.push_back(row_out[i]);
        clear_row();
    endfunction

    function automatic void model_accept();
        if (row_open && in_first) close_row();
        if (!row_open) begin
            row_open = 1;
            row_mode = int'(cfg_mode);
        end
        for (int l = 0; l < L; l++) begin
            rt.push_back(int'(in_top[l*W +: W]));
            rm.push_back(int'(in_mid[l*W +: W]));
            rb.push_back(int'(in_bot[l*W +: W]));
        end
        row_words++;
        if (in_last) close_row();
    endfunction

    // On reset, outputs already delivered from the open row must match the
    // row prefix; everything else is discarded.
    task automatic model_reset();
        int n;
        if (row_open && row_words > 1) begin
            build_row();
            n = (obs_q.size() < row_words - 1) ? obs_q.size() : row_words - 1;
            for (int i = 0; i < n; i++) chk("reset_prefix", obs_q[i], row_out[i]);
        end
        clear_row();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic match();
        logic [DW:0] o, e;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk("word", o, e);
        end
    endtask

    // One clock: sample handshakes mid-cycle, then step past the edge.
    task automatic cycle();
        @(negedge clk);
        last_acc = in_valid && in_ready && !rst;
        if (rst) model_reset();
        if (last_acc) model_accept();
        if (!rst && out_valid && out_ready) begin
            obs_q.push_back({out_last, out_pix});
            out_log.push_back({out_last, out_pix});
        end
        match();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [DW-1:0] t, input logic [DW-1:0] m,
                        input logic [DW-1:0] b, input logic f, input logic l);
        in_top = t; in_mid = m; in_bot = b;
        in_first = f; in_last = l;
        in_valid = 1'b1;
        last_acc = 0;
        for (int k = 0; k < 200; k++) begin
            cycle();
            if (last_acc) break;
        end
        if (!last_acc) chk("send_timeout", 64'(last_acc), 64'd1);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 1000; k++) begin
            if (!busy && exp_q.size() == 0 && obs_q.size() == 0) break;
            cycle();
        end
        chk("drain_busy", 64'(busy), 64'd0);
        chk("drain_exp_left", 64'(exp_q.size()), 64'd0);
        chk("drain_obs_left", 64'(obs_q.size()), 64'd0);
    endtask

    function automatic logic [W-1:0] rpix();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return '1;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [DW-1:0] t, m, b;
        int nw;
        bit abandon_prev, abandon;

        rst = 1'b1; cfg_mode = 2'd0; in_valid = 1'b0; in_first = 1'b0;
        in_last = 1'b0; in_top = '0; in_mid = '0; in_bot = '0; out_ready = 1'b1;

        // Reset state
        cycle(); cycle();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_pix", 64'(out_pix), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        cycle();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // PASS, two-word row
        out_log.delete();
        cfg_mode = 2'd0;
        send(32'h0, 32'h04030201, 32'h0, 1'b1, 1'b0);
        send(32'h0, 32'h08070605, 32'h0, 1'b0, 1'b1);
        drain();
        chk("pass_count", 64'(out_log.size()), 64'd2);
        chk("pass_w0", out_log[0], {1'b0, 32'h04030201});
        chk("pass_w1", out_log[1], {1'b1, 32'h08070605});

        // GAUSS on a flat 0x80 field
        out_log.delete();
        cfg_mode = 2'd1;
        for (int k = 0; k < 3; k++)
            send(32'h80808080, 32'h80808080, 32'h80808080, k == 0, k == 2);
        drain();
        chk("gauss_count", 64'(out_log.size()), 64'd3);
        for (int k = 0; k < 3; k++)
            chk("gauss_word", out_log[k], {(k == 2), 32'h80808080});

        // SOBEL, horizontal edge, single word
        out_log.delete();
        cfg_mode = 2'd2;
        send(32'h0, 32'h80808080, 32'hFFFFFFFF, 1'b1, 1'b1);
        chk("sobel_drain_ready", 64'(in_ready), 64'd0);
        cycle();
        chk("sobel_ready_back", 64'(in_ready), 64'd1);
        drain();
        chk("sobel_word", out_log[0], {1'b1, 32'hFFFFFFFF});

        // SHARP, alternating columns, single word
        out_log.delete();
        cfg_mode = 2'd3;
        send(32'h0, 32'h00FF00FF, 32'h0, 1'b1, 1'b1);
        drain();
        chk("sharp_word", out_log[0], {1'b1, 32'h00FF00FF});

        // Output stall during a row
        out_log.delete();
        cfg_mode = 2'd0;
        out_ready = 1'b0;
        send(32'h0, 32'h11111111, 32'h0, 1'b1, 1'b0);
        send(32'h0, 32'h22222222, 32'h0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("stall_pix", out_pix, 32'h11111111);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            cycle();
        end
        out_ready = 1'b1;
        send(32'h0, 32'h33333333, 32'h0, 1'b0, 1'b0);
        send(32'h0, 32'h44444444, 32'h0, 1'b0, 1'b1);
        drain();
        chk("stall_count", 64'(out_log.size()), 64'd4);
        chk("stall_w0", out_log[0], {1'b0, 32'h11111111});
        chk("stall_w1", out_log[1], {1'b0, 32'h22222222});
        chk("stall_w2", out_log[2], {1'b0, 32'h33333333});
        chk("stall_w3", out_log[3], {1'b1, 32'h44444444});

        // Reset in the middle of a row, then a fresh row with left replication
        out_log.delete();
        cfg_mode = 2'd0;
        send(32'h0, 32'hAA000000, 32'h0, 1'b1, 1'b0);
        send(32'h0, 32'hBB000000, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        cfg_mode = 2'd3;
        send(32'h0, 32'h00002020, 32'h0, 1'b0, 1'b1);
        drain();
        chk("midrst_count", 64'(out_log.size()), 64'd1);
        chk("midrst_word", out_log[0], {1'b1, 32'h00008060});

        // Randomized rows, random modes, gaps, back-pressure and abandons
        rand_ready = 1;
        abandon_prev = 0;
        for (int r = 0; r < 40; r++) begin
            nw = $urandom_range(1, 5);
            abandon = (r != 39) && ($urandom_range(0, 4) == 0);
            for (int k = 0; k < nw; k++) begin
                for (int l = 0; l < L; l++) begin
                    t[l*W +: W] = rpix();
                    m[l*W +: W] = rpix();
                    b[l*W +: W] = rpix();
                end
                cfg_mode = 2'($urandom_range(0, 3));
                repeat ($urandom_range(0, 2)) cycle();
                send(t, m, b,
                     (k == 0) && (abandon_prev || ($urandom_range(0, 1) == 1)),
                     (k == nw - 1) && !abandon);
            end
            abandon_prev = abandon;
        end
        drain();
        rand_ready = 0;
        out_ready = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_pixel_stencil
`default_nettype wire

// File: doc/pixel_stencil.md
PIXEL_STENCIL -- requirements
Module: pixel_stencil

Interface
REQ-001 SHALL have parameter LANES, default 4, giving the number of pixels per word (legal values 1..8).
REQ-002 SHALL have parameter PIX_W, default 8, giving the unsigned pixel width in bits (legal values 4..16).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port cfg_mode, input, 2 bits: kernel select, with values PASS=0, GAUSS=1, SOBEL=2, SHARP=3.
REQ-006 SHALL have ports in_top, in_mid and in_bot, inputs, LANES*PIX_W bits each: three vertically adjacent row words; lane 0 is at bits [PIX_W-1:0] and is leftmost.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_first (input, 1) and in_last (input, 1): input handshake plus row-start and row-end markers.
REQ-008 SHALL have ports out_pix (output, LANES*PIX_W), out_valid (output, 1), out_ready (input, 1) and out_last (output, 1): the result word, its handshake, and a row-end marker.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the state is not EMPTY or out_valid is high.

Function
REQ-010 SHALL accept an input word in any cycle where in_valid and in_ready are both high, and SHALL emit an output word in any cycle where out_valid and out_ready are both high.
REQ-011 SHALL hold out_pix and out_last stable while out_valid=1 and out_ready=0.
REQ-012 SHALL implement a state machine with states EMPTY, HOLD and DRAIN, where one pending word (top/mid/bot) is held in the HOLD and DRAIN states.
REQ-013 EMPTY: on accept, SHALL treat the word as a row start whatever in_first is, store it as pending, latch cfg_mode for the row, and go to DRAIN if in_last is set, otherwise to HOLD; SHALL produce no output.
REQ-014 HOLD without in_first: on accept, SHALL compute the pending word using lane 0 of the new word as its right neighbour, load the result into the output register with out_last=0, store the new word as pending, and go to DRAIN if in_last is set, otherwise stay in HOLD.
REQ-015 HOLD with in_first (a row abandoned without in_last): SHALL emit the pending word with its right edge replicated and out_last=1, and start a new row as in REQ-013.
REQ-016 DRAIN: SHALL hold in_ready=0; when the output register is free, SHALL load the pending word with its right edge replicated and out_last=1, then go to EMPTY.
REQ-017 SHALL drive in_ready = (state != DRAIN) && (!out_valid || out_ready), so the output register is never overwritten before it is consumed.
REQ-018 For the left neighbour, SHALL use the registered lane LANES-1 of the previous word in the same row, or the replicated lane 0 on the first word of a row.
REQ-019 SHALL produce output word k in the cycle after word k+1 is accepted, or in the cycle after DRAIN is entered if word k is the last word of its row.
REQ-020 PASS mode: each output pixel SHALL equal the centre pixel.
REQ-021 GAUSS mode: each output pixel SHALL equal (weighted 3x3 sum with weights 1 2 1 / 2 4 2 / 1 2 1, plus 8) >> 4.
REQ-022 SOBEL mode: each output pixel SHALL equal min(|gx|+|gy|, 2^PIX_W-1), using the standard 3x3 Sobel kernels for gx and gy.
REQ-023 SHARP mode: each output pixel SHALL equal clamp(5c-n-s-e-w, 0, 2^PIX_W-1), where c is the centre and n/s/e/w are its four direct neighbours.
REQ-024 SHALL size all intermediate sums at PIX_W+4 bits signed so that no intermediate overflow occurs.
REQ-025 SHALL ignore changes to cfg_mode in the middle of a row.

Reset
REQ-026 While rst=1, SHALL set state=EMPTY, out_valid=0, out_pix=0, out_last=0 and in_ready=0, and clear the pending word and left-neighbour registers.
REQ-027 In the cycle after rst deasserts, SHALL drive in_ready=1, and SHALL treat the first word accepted as a row start.
REQ-028 On reset asserted in the middle of a row, SHALL discard any pending or unconsumed output word.

Structure
REQ-029 SHALL define the stencil_mode_t enum (PASS, GAUSS, SOBEL, SHARP) in the shared types package.
REQ-030 SHALL implement the per-pixel arithmetic in one sub-module, stencil_lane, which is purely combinational, takes a 3x3 neighbourhood plus the mode, and is instantiated LANES times through a generate loop.
REQ-031 SHALL keep the state machine, pending word and output register in pixel_stencil.

Verification (LANES=4, PIX_W=8)
REQ-032 PASS mode, mid=0x04030201 then 0x08070605 with in_last on the second -> output 0x04030201 with out_last=0, then 0x08070605 with out_last=1.
REQ-033 GAUSS mode, all pixels 0x80 over a 3-word row -> three output words of 0x80808080, with out_last=1 only on the third.
REQ-034 SOBEL mode, top=0, bot=0xFFFFFFFF, single word with in_first and in_last -> output 0xFFFFFFFF with out_last=1, and in_ready=0 for one cycle.
REQ-035 SHARP mode, mid=0x00FF00FF, top=bot=0, single word -> output 0x00FF00FF.
REQ-036 out_ready held at 0 for 5 cycles during a row -> out_pix stays stable, in_ready=0 once the output register is full, and after release every word is delivered in order with none lost or duplicated.
REQ-037 rst pulsed for 1 cycle after the second word of a 4-word row -> out_valid=0 next cycle, state returns to EMPTY, and the next accepted word starts a new row with left-edge replication.
